f2h_bridge_master: RTL and testbench
====================================

# f2h_bridge_master

Avalon-MM initiator that turns single fabric-side commands into single-beat Avalon-MM reads and writes toward an HPS/interconnect slave, and returns one response per command. It is the opposite end of our H2F register-bank slave: fabric logic drives this block instead of the HPS driving the fabric. It honours `waitrequest`, tolerates zero or variable read latency, and aborts any access that exceeds a configurable timeout.

## Interface
- `ADDRWIDTH`, 10, Avalon byte-address width.
- `DATAWIDTH`, 64, data width; multiple of 8.
- `TIMEOUT_CYCLES`, 1024, stall limit per phase; 0 disables the timeout.
- Clocking: one clock; reset is asynchronous and active-low.
- `i_clk` in 1 — clock.
- `i_arstn` in 1 — asynchronous active-low reset.
- `cmd_valid` in 1 — command offered.
- `cmd_ready` out 1 — command accepted when `cmd_valid` and `cmd_ready` are both high.
- `cmd_write` in 1 — 1 = write, 0 = read.
- `cmd_address` in ADDRWIDTH — byte address.
- `cmd_writedata` in DATAWIDTH — write data.
- `cmd_byteenable` in DATAWIDTH/8 — byte lanes.
- `rsp_valid` out 1 — response available.
- `rsp_ready` in 1 — response consumed.
- `rsp_readdata` out DATAWIDTH — read data; 0 for writes and errors.
- `rsp_error` out 1 — timeout occurred.
- `address` out ADDRWIDTH — Avalon address; low log2(DATAWIDTH/8) bits forced to 0.
- `read`, `write` out 1 — Avalon strobes.
- `writedata` out DATAWIDTH; `byteenable` out DATAWIDTH/8.
- `burstcount` out 1 — constant 1.
- `readdata` in DATAWIDTH; `readdatavalid` in 1; `waitrequest` in 1.

## Operation
- States:
  - IDLE: `cmd_ready`=1. On handshake, register address (aligned), data, and byteenable, then go to WRITE or READ_CMD.
  - WRITE: `write`=1, with address, data, and byteenable held stable. When `waitrequest`=0, go to RESP with `rsp_error`=0 and `rsp_readdata`=0.
  - READ_CMD: `read`=1, held stable.
    - `waitrequest`=0 with `readdatavalid`=1 in the same cycle: capture `readdata` and go to RESP.
    - `waitrequest`=0 with `readdatavalid`=0: go to READ_WAIT.
  - READ_WAIT: strobes low. On `readdatavalid`=1, capture `readdata` and go to RESP.
  - RESP: `rsp_valid`=1 and the response is held. When `rsp_ready`=1, go to IDLE.
- Timeout:
  - A wait counter clears on entry to WRITE, READ_CMD and READ_WAIT, and increments each cycle spent in those states.
  - When the counter reaches `TIMEOUT_CYCLES` (if nonzero), drop the strobes and go to RESP with `rsp_error`=1 and `rsp_readdata`=0.
  - The counter saturates and never wraps.
- `readdatavalid` arriving in IDLE, WRITE or RESP (for example, late data after a timeout) is ignored.
- Only one transaction is outstanding at any time.

## Timing
- Reset values: all outputs 0, including `cmd_ready`; state IDLE. `cmd_ready` rises in the first cycle after reset deassertion.
- Assertion of `i_arstn` mid-transaction drops `read`/`write` immediately (asynchronously) and discards the pending response.
- A strobe appears in the cycle after the command handshake. With `waitrequest`=0 and zero read latency, `rsp_valid` is high 2 cycles after the handshake.
- The next `cmd_ready` comes no earlier than the cycle after the `rsp_valid`/`rsp_ready` handshake. Minimum command spacing is 3 cycles.
- Avalon outputs are registered and stay constant while `waitrequest`=1.
- Timeout with limit N: the error response appears N+1 cycles after phase entry.

## Structure
- Package `f2h_bridge_pkg` holds:
  - the state enum `f2h_state_t` (IDLE, WRITE, READ_CMD, READ_WAIT, RESP);
  - a `BYTE_COUNT` function/constant;
  - an address-align mask helper.
- Sub-module `wait_timer`: a saturating counter with `clear`, `enable` and `expired` ports, sized $clog2(TIMEOUT_CYCLES+1).

## Test plan
- Write to 0x010 with data 0xDEADBEEF_CAFEF00D and byteenable 0xFF; slave holds `waitrequest` for 3 cycles. Expect `write` high for 4 cycles with stable signals, then `rsp_valid` with `rsp_error`=0.
- Read from 0x018; slave drops `waitrequest` and asserts `readdatavalid` with 0x1234 in the same cycle. Expect `rsp_readdata`=0x1234 two cycles after the handshake.
- Read with `readdatavalid` 5 cycles after acceptance. Expect strobes low during the wait, and `rsp_readdata` equal to the captured value.
- `TIMEOUT_CYCLES`=8 and `waitrequest` stuck at 1. Expect `read` to drop after 9 cycles, then `rsp_error`=1 and `rsp_readdata`=0. A late `readdatavalid` is ignored and the next command proceeds.
- Back-to-back commands with `rsp_ready` low for 4 cycles. Expect `rsp_valid` and the response held, `cmd_ready` low, and no new strobe.
- Assert `i_arstn` during WRITE with `waitrequest`=1. Expect `write`=0 immediately, and IDLE with `cmd_ready`=1 after release.

Source files
------------

// File: rtl/f2h_bridge_pkg.sv
// f2h_bridge_pkg: shared types and helpers for the
// fabric-to-HPS Avalon-MM bridge master.
package f2h_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WRITE     = 3'd1,
    READ_CMD  = 3'd2,
    READ_WAIT = 3'd3,
    RESP      = 3'd4
  } f2h_state_t;

  function automatic int unsigned byte_count(
    input int unsigned dw
  );
    return dw / 8;
  endfunction

  // Clears the byte-offset bits of a bus-word address.
  function automatic logic [63:0] align_mask(
    input int unsigned dw
  );
    return ~(64'(byte_count(dw)) - 64'd1);
  endfunction

endpackage

// File: rtl/f2h_bridge_master_if.sv
// f2h_bridge_master_if: fabric command/response
// handshakes plus the Avalon-MM initiator bus.
interface f2h_bridge_master_if #(
  parameter int ADDRWIDTH = 10,
  parameter int DATAWIDTH = 64
);

  logic                   cmd_valid;
  logic                   cmd_ready;
  logic                   cmd_write;
  logic [ADDRWIDTH-1:0]   cmd_address;
  logic [DATAWIDTH-1:0]   cmd_writedata;
  logic [DATAWIDTH/8-1:0] cmd_byteenable;

  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [DATAWIDTH-1:0]   rsp_readdata;
  logic                   rsp_error;

  logic [ADDRWIDTH-1:0]   address;
  logic                   read;
  logic                   write;
  logic [DATAWIDTH-1:0]   writedata;
  logic [DATAWIDTH/8-1:0] byteenable;
  logic                   burstcount;
  logic [DATAWIDTH-1:0]   readdata;
  logic                   readdatavalid;
  logic                   waitrequest;

  modport master (
    input  cmd_valid, cmd_write,
    input  cmd_address, cmd_writedata,
    input  cmd_byteenable, rsp_ready,
    input  readdata, readdatavalid,
    input  waitrequest,
    output cmd_ready, rsp_valid,
    output rsp_readdata, rsp_error,
    output address, read, write,
    output writedata, byteenable,
    output burstcount
  );

  modport slave (
    output cmd_valid, cmd_write,
    output cmd_address, cmd_writedata,
    output cmd_byteenable, rsp_ready,
    output readdata, readdatavalid,
    output waitrequest,
    input  cmd_ready, rsp_valid,
    input  rsp_readdata, rsp_error,
    input  address, read, write,
    input  writedata, byteenable,
    input  burstcount
  );

endinterface

// File: rtl/f2h_bridge_master_wait_timer.sv
// wait_timer: saturating stall counter; expired marks
// the configured limit (limit 0 never expires).
module wait_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam bit ON = TIMEOUT_CYCLES > 0;
  localparam int W =
    ON ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [W-1:0] TOP =
    ON ? W'(TIMEOUT_CYCLES) : '1;

  logic [W-1:0] count;

  // Count stalled cycles, holding at the top value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && count != TOP) begin
      count <= count + W'(1);
    end
  end

  assign expired = ON && (count == TOP);

endmodule

// File: rtl/f2h_bridge_master.sv
// f2h_bridge_master: one fabric command becomes one
// single-beat Avalon-MM access and one response.
module f2h_bridge_master
  import f2h_bridge_pkg::*;
#(
  parameter int ADDRWIDTH      = 10,
  parameter int DATAWIDTH      = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic i_clk,
  input logic i_arstn,
  f2h_bridge_master_if.master bus
);

  localparam int BEW =
    int'(byte_count(DATAWIDTH));
  localparam logic [ADDRWIDTH-1:0] AMASK =
    ADDRWIDTH'(align_mask(DATAWIDTH));

  f2h_state_t state;

  logic                 cmd_ready;
  logic                 rsp_valid;
  logic                 rsp_error;
  logic [DATAWIDTH-1:0] rsp_data;
  logic                 rd;
  logic                 wr;
  logic [ADDRWIDTH-1:0] addr;
  logic [DATAWIDTH-1:0] wdata;
  logic [BEW-1:0]       be;

  logic accept;
  logic phase;
  logic clear;
  logic expired;

  assign accept = cmd_ready && bus.cmd_valid;

  assign phase = (state == WRITE)
              || (state == READ_CMD)
              || (state == READ_WAIT);

  // Restart the stall budget on every phase entry.
  assign clear = accept
              || ((state == READ_CMD)
                  && !bus.waitrequest
                  && !bus.readdatavalid);

  wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (i_clk),
    .rst_n  (i_arstn),
    .clear  (clear),
    .enable (phase),
    .expired(expired)
  );

  // Sequence command, Avalon access and response.
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      rsp_data  <= '0;
      rd        <= 1'b0;
      wr        <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      be        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            cmd_ready <= 1'b0;
            addr      <= bus.cmd_address & AMASK;
            wdata     <= bus.cmd_writedata;
            be        <= bus.cmd_byteenable;
            rsp_data  <= '0;
            rsp_error <= 1'b0;
            if (bus.cmd_write) begin
              wr    <= 1'b1;
              state <= WRITE;
            end else begin
              rd    <= 1'b1;
              state <= READ_CMD;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        WRITE: begin
          if (!bus.waitrequest) begin
            wr        <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (expired) begin
            wr        <= 1'b0;
            rsp_error <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        READ_CMD: begin
          if (!bus.waitrequest) begin
            rd <= 1'b0;
            if (bus.readdatavalid) begin
              rsp_data  <= bus.readdata;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              state <= READ_WAIT;
            end
          end else if (expired) begin
            rd        <= 1'b0;
            rsp_error <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        READ_WAIT: begin
          if (bus.readdatavalid) begin
            rsp_data  <= bus.readdata;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (expired) begin
            rsp_error <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          rd        <= 1'b0;
          wr        <= 1'b0;
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready    = cmd_ready;
  assign bus.rsp_valid    = rsp_valid;
  assign bus.rsp_error    = rsp_error;
  assign bus.rsp_readdata = rsp_data;
  assign bus.address      = addr;
  assign bus.read         = rd;
  assign bus.write        = wr;
  assign bus.writedata    = wdata;
  assign bus.byteenable   = be;
  assign bus.burstcount   = 1'b1;

endmodule

// File: tb/tb_f2h_bridge_master.sv
// tb_f2h_bridge_master: directed table plus random
// transactions against a latency/response model.
module tb_f2h_bridge_master;

  localparam int AW  = 10;
  localparam int DW  = 64;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic arstn;

  always #5 clk = ~clk;

  f2h_bridge_master_if #(
    .ADDRWIDTH(AW),
    .DATAWIDTH(DW)
  ) bus ();

  f2h_bridge_master #(
    .ADDRWIDTH     (AW),
    .DATAWIDTH     (DW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk  (clk),
    .i_arstn(arstn),
    .bus    (bus.master)
  );

  typedef struct {
    logic        wr;
    logic [9:0]  addr;
    logic [63:0] wdata;
    logic [7:0]  be;
    int          stall;
    int          lat;
    logic [63:0] rdata;
    int          hold;
    logic        late;
    logic [9:0]  exp_addr;
    int          exp_lat;
    int          exp_strb;
    logic        exp_err;
    logic [63:0] exp_rdata;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  int          cfg_stall = 0;
  int          cfg_lat   = 0;
  logic [63:0] cfg_rdata = '0;
  int          late_req  = 0;

  task automatic chk(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(
    input logic        wr,
    input logic [9:0]  addr,
    input logic [63:0] wdata,
    input logic [7:0]  be,
    input int          stall,
    input int          lat,
    input logic [63:0] rdata,
    input int          hold,
    input logic        late,
    input logic [9:0]  exp_addr,
    input int          exp_lat,
    input int          exp_strb,
    input logic        exp_err,
    input logic [63:0] exp_rdata
  );
    vec_t v;
    v.wr = wr; v.addr = addr;
    v.wdata = wdata; v.be = be;
    v.stall = stall; v.lat = lat;
    v.rdata = rdata; v.hold = hold;
    v.late = late;
    v.exp_addr = exp_addr;
    v.exp_lat = exp_lat;
    v.exp_strb = exp_strb;
    v.exp_err = exp_err;
    v.exp_rdata = exp_rdata;
    return v;
  endfunction

  // Response timing from the access rules: strobe one
  // cycle after handshake, one cycle per wait state up
  // to the limit, then read latency, then response.
  function automatic vec_t ref_model(input vec_t v);
    vec_t r;
    bit   to;
    int   s;
    r  = v;
    to = v.stall > TMO;
    s  = to ? TMO : v.stall;
    r.exp_addr  = v.addr & 10'h3F8;
    r.exp_err   = to;
    r.exp_rdata = (v.wr || to) ? 64'd0 : v.rdata;
    r.exp_strb  = s + 1;
    r.exp_lat   = 2 + s + ((!v.wr && !to) ? v.lat : 0);
    return r;
  endfunction

  // Avalon slave: stalls cfg_stall cycles, returns data
  // cfg_lat cycles after acceptance, junk otherwise.
  initial begin : slave
    int wcnt;
    int pend;
    int late_seen;
    wcnt = 0;
    pend = 0;
    late_seen = 0;
    bus.waitrequest   = 1'b0;
    bus.readdatavalid = 1'b0;
    bus.readdata      = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.readdatavalid = 1'b0;
      bus.readdata = {$urandom, $urandom};
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.readdatavalid = 1'b1;
          bus.readdata = cfg_rdata;
        end
      end
      if (late_seen != late_req) begin
        late_seen = late_req;
        bus.readdatavalid = 1'b1;
        bus.readdata = 64'hBAD0_BAD0_BAD0_BAD0;
      end
      if (bus.read || bus.write) begin
        if (wcnt < cfg_stall) begin
          bus.waitrequest = 1'b1;
          wcnt++;
        end else begin
          bus.waitrequest = 1'b0;
          wcnt = 0;
          if (bus.read) begin
            if (cfg_lat == 0) begin
              bus.readdatavalid = 1'b1;
              bus.readdata = cfg_rdata;
            end else begin
              pend = cfg_lat;
            end
          end
        end
      end else begin
        bus.waitrequest = 1'b0;
        wcnt = 0;
      end
    end
  end

  task automatic run_txn(input vec_t v);
    int n;
    int strb;
    cfg_stall = v.stall;
    cfg_lat   = v.lat;
    cfg_rdata = v.rdata;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin
      step();
      n++;
    end
    chk("cmd_ready", 64'(bus.cmd_ready), 64'd1);
    bus.cmd_valid      = 1'b1;
    bus.cmd_write      = v.wr;
    bus.cmd_address    = v.addr;
    bus.cmd_writedata  = v.wdata;
    bus.cmd_byteenable = v.be;
    step();
    bus.cmd_valid = 1'b0;
    n = 1;
    strb = 0;
    while (!bus.rsp_valid && n < 40) begin
      if (bus.read || bus.write) begin
        strb++;
        chk("strobe_write", 64'(bus.write),
            64'(v.wr));
        chk("strobe_read", 64'(bus.read),
            64'(!v.wr));
        chk("address", 64'(bus.address),
            64'(v.exp_addr));
        if (v.wr) begin
          chk("writedata", bus.writedata, v.wdata);
          chk("byteenable", 64'(bus.byteenable),
              64'(v.be));
        end
      end
      step();
      n++;
    end
    chk("rsp_latency", 64'(n), 64'(v.exp_lat));
    chk("strobe_cycles", 64'(strb),
        64'(v.exp_strb));
    chk("rsp_error", 64'(bus.rsp_error),
        64'(v.exp_err));
    chk("rsp_readdata", bus.rsp_readdata,
        v.exp_rdata);
    chk("strobe_in_resp",
        64'(bus.read | bus.write), 64'd0);
    if (v.late) late_req++;
    for (int i = 0; i < v.hold; i++) begin
      bus.cmd_valid = 1'b1;
      step();
      chk("hold_valid", 64'(bus.rsp_valid), 64'd1);
      chk("hold_data", bus.rsp_readdata,
          v.exp_rdata);
      chk("hold_error", 64'(bus.rsp_error),
          64'(v.exp_err));
      chk("hold_cmd_ready", 64'(bus.cmd_ready),
          64'd0);
      chk("hold_no_strobe",
          64'(bus.read | bus.write), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b0;
    chk("rsp_drop", 64'(bus.rsp_valid), 64'd0);
    chk("cmd_ready_back", 64'(bus.cmd_ready), 64'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin : main
    vec_t tbl[10];
    vec_t v;
    int   n;

    tbl[0] = mk(1, 10'h010, 64'hDEADBEEF_CAFEF00D,
                8'hFF, 3, 0, 64'h0, 0, 0,
                10'h010, 5, 4, 0, 64'h0);
    tbl[1] = mk(0, 10'h018, 64'h0, 8'h00, 0, 0,
                64'h1234, 0, 0,
                10'h018, 2, 1, 0, 64'h1234);
    tbl[2] = mk(0, 10'h020, 64'h0, 8'h00, 0, 5,
                64'h5555_AAAA_0000_FFFF, 0, 0,
                10'h020, 7, 1, 0,
                64'h5555_AAAA_0000_FFFF);
    tbl[3] = mk(0, 10'h030, 64'h0, 8'h00, 20, 0,
                64'h99, 3, 1,
                10'h030, 10, 9, 1, 64'h0);
    tbl[4] = mk(1, 10'h0FF, 64'h0123_4567_89AB_CDEF,
                8'h0F, 0, 0, 64'h0, 4, 0,
                10'h0F8, 2, 1, 0, 64'h0);
    tbl[5] = mk(0, 10'h107, 64'h0, 8'h00, 2, 1,
                64'h77, 0, 0,
                10'h100, 5, 3, 0, 64'h77);
    tbl[6] = mk(1, 10'h200, 64'h1111, 8'h81, 8, 0,
                64'h0, 0, 0,
                10'h200, 10, 9, 0, 64'h0);
    tbl[7] = mk(1, 10'h208, 64'h2222, 8'h3C, 9, 0,
                64'h0, 0, 0,
                10'h208, 10, 9, 1, 64'h0);
    tbl[8] = mk(0, 10'h3F8, 64'h0, 8'h00, 0, 9,
                64'hCAFE, 0, 0,
                10'h3F8, 11, 1, 0, 64'hCAFE);
    tbl[9] = mk(0, 10'h3F0, 64'h0, 8'h00, 1, 10,
                64'hBEEF, 2, 0,
                10'h3F0, 12, 2, 1, 64'h0);

    arstn              = 1'b0;
    bus.cmd_valid      = 1'b0;
    bus.cmd_write      = 1'b0;
    bus.cmd_address    = '0;
    bus.cmd_writedata  = '0;
    bus.cmd_byteenable = '0;
    bus.rsp_ready      = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    chk("reset_read", 64'(bus.read), 64'd0);
    chk("reset_write", 64'(bus.write), 64'd0);
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset_rsp_error", 64'(bus.rsp_error), 64'd0);
    chk("reset_rsp_data", bus.rsp_readdata, 64'd0);
    chk("reset_address", 64'(bus.address), 64'd0);
    arstn = 1'b1;
    chk("cmd_ready_pre", 64'(bus.cmd_ready), 64'd0);
    step();
    chk("cmd_ready_rise", 64'(bus.cmd_ready), 64'd1);

    for (int i = 0; i < 10; i++) run_txn(tbl[i]);

    late_req++;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_late_valid", 64'(bus.rsp_valid),
          64'd0);
      chk("idle_late_ready", 64'(bus.cmd_ready),
          64'd1);
    end

    cfg_stall = 1000;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin
      step();
      n++;
    end
    bus.cmd_valid   = 1'b1;
    bus.cmd_write   = 1'b1;
    bus.cmd_address = 10'h040;
    step();
    bus.cmd_valid = 1'b0;
    step();
    step();
    chk("rst_write_before", 64'(bus.write), 64'd1);
    #2;
    arstn = 1'b0;
    #1;
    chk("rst_write_async", 64'(bus.write), 64'd0);
    chk("rst_read_async", 64'(bus.read), 64'd0);
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    @(posedge clk);
    #1;
    arstn = 1'b1;
    cfg_stall = 0;
    step();
    chk("rst_cmd_ready_rise", 64'(bus.cmd_ready),
        64'd1);
    chk("rst_no_rsp", 64'(bus.rsp_valid), 64'd0);
    chk("rst_no_write", 64'(bus.write), 64'd0);

    for (int i = 0; i < 40; i++) begin
      v.wr    = 1'($urandom);
      v.addr  = 10'($urandom);
      v.wdata = {$urandom, $urandom};
      v.be    = 8'($urandom);
      v.stall = int'($urandom_range(11, 0));
      v.lat   = int'($urandom_range(9, 0));
      v.rdata = {$urandom, $urandom};
      v.hold  = int'($urandom_range(3, 0));
      v.late  = 1'b0;
      run_txn(ref_model(v));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
